// File: rtl/systolic_skew_feeder_if.sv
// Input beat handshake for the systolic edge feeder.
// One N-lane column vector per accepted beat.
interface systolic_skew_feeder_if #(
  parameter int N          = 4,
  parameter int DATA_WIDTH = 32
);
  logic                    in_valid;
  logic                    in_ready;
  logic [N*DATA_WIDTH-1:0] in_data;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready
  );
endinterface

// File: rtl/systolic_skew_feeder.sv
// Systolic array edge feeder: skews lane i by i cycles, then drains.
// Optional stall counter port enabled by FEEDER_STALL_CNT_EN.
module systolic_skew_feeder #(
  parameter int N          = 4,
  parameter int DATA_WIDTH = 32,
  parameter int K_WIDTH    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [K_WIDTH-1:0]      k_len,
  systolic_skew_feeder_if.slave   in_bus,
  output logic [N*DATA_WIDTH-1:0] out_data,
  output logic                    busy,
  output logic                    done
`ifdef FEEDER_STALL_CNT_EN
  ,
  output logic [K_WIDTH-1:0]      stall_cnt
`endif
);

  localparam int FW = $clog2(2 * N);
  localparam logic [FW-1:0] F_LAST = FW'(2 * N - 2);

  typedef enum logic [1:0] {
    IDLE,
    FEED,
    FLUSH,
    DONE
  } state_t;

  state_t               state_q;
  state_t               state_d;
  logic [K_WIDTH-1:0]   k_q;
  logic [K_WIDTH-1:0]   beat_q;
  logic [FW-1:0]        flush_q;
  logic                 start_acc;
  logic                 accept;
  logic                 last_beat;
  logic [N*DATA_WIDTH-1:0] feed_vec;

  assign start_acc = (state_q == IDLE) && start;
  assign accept    = (state_q == FEED) && in_bus.in_valid;
  assign last_beat = accept && (beat_q == k_q - 1'b1);
  assign feed_vec  = accept ? in_bus.in_data : '0;

  assign in_bus.in_ready = (state_q == FEED);
  assign busy            = (state_q != IDLE);
  assign done            = (state_q == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = (k_len == '0) ? DONE : FEED;
        end
      end
      FEED: begin
        if (last_beat) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (flush_q == F_LAST) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      k_q     <= '0;
      beat_q  <= '0;
      flush_q <= '0;
    end else begin
      if (start_acc) begin
        k_q    <= k_len;
        beat_q <= '0;
      end else if (accept) begin
        beat_q <= beat_q + 1'b1;
      end
      if (state_q == FLUSH) begin
        flush_q <= flush_q + 1'b1;
      end else begin
        flush_q <= '0;
      end
    end
  end

  // Lane i is an (i+1)-deep shift chain; bubbles shift zeros.
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [DATA_WIDTH-1:0] line [i+1];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int j = 0; j <= i; j++) begin
          line[j] <= '0;
        end
      end else begin
        line[0] <= feed_vec[i*DATA_WIDTH +: DATA_WIDTH];
        for (int j = 1; j <= i; j++) begin
          line[j] <= line[j-1];
        end
      end
    end

    assign out_data[i*DATA_WIDTH +: DATA_WIDTH] = line[i];
  end

`ifdef FEEDER_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (start_acc) begin
      stall_cnt <= '0;
    end else if ((state_q == FEED) && !in_bus.in_valid &&
                 (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: doc/systolic_skew_feeder.md
Name: systolic_skew_feeder

Overview:
Upstream edge feeder for the systolic matmul array. It accepts one N-element column vector of matrix A per beat over a valid/ready handshake and drives the array's west edge, with lane i delayed by i cycles to form the systolic skew. Lanes with no data carry zero, so the processing elements accumulate nothing from them. It sequences one K-length matmul pass, drains the skew and array pipeline, then pulses done. An identical instance fed with B in lockstep (sharing in_valid) drives the north edge.

Parameters:
N, 4, array dimension (number of lanes); N >= 2
DATA_WIDTH, 32, bits per element; matches the PE data width
K_WIDTH, 16, width of the inner-dimension length k_len

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous, active-high reset
start  input  1  one-cycle request to begin a pass; sampled in IDLE only
k_len  input  K_WIDTH  number of beats in the pass; latched on accepted start
in_valid  input  1  in_data holds a valid beat
in_ready  output  1  feeder accepts a beat this cycle
in_data  input  N*DATA_WIDTH  lane i = bits [i*DATA_WIDTH +: DATA_WIDTH]
out_data  output  N*DATA_WIDTH  west-edge drive; lane i feeds array row i
busy  output  1  high in FEED, FLUSH and DONE
done  output  1  one-cycle pulse; all PE results are final

Behaviour:
- Reset: clk is the single clock; rst is synchronous and active-high. When rst is high at a clk edge: state=IDLE, all skew registers cleared. Resulting outputs: out_data=0, in_ready=0, busy=0, done=0, beat and flush counters=0. rst mid-pass aborts the pass with no done pulse.
- FSM states: IDLE, FEED, FLUSH, DONE.
- IDLE -> FEED: start=1 and k_len!=0. k_len is latched, and the beat counter and in_ready are asserted from the next cycle.
- IDLE -> DONE: start=1 and k_len==0. No beats are accepted; done pulses in the following cycle.
- start outside IDLE is ignored.
- FEED:
  - in_ready=1.
  - A beat is accepted when in_valid & in_ready at an edge.
  - On each accepted beat, lane 0 loads element 0 into stage 0 of its delay line.
  - When in_valid=0 in FEED, a zero vector (bubble) enters the delay lines instead; the beat counter does not advance.
  - Transition to FLUSH on the edge that accepts beat k_len. in_ready is 0 from the next cycle.
- Skew: lane i uses an i+1 stage register chain. A beat accepted at edge T appears on lane i of out_data after edge T+i. out_data is registered; there is no combinational path from in_data.
- FLUSH:
  - In_ready=0; zeros are shifted into all delay lines.
  - Lasts exactly 2N-1 cycles (flush counter 0..2N-2). This covers N-1 cycles of skew drain plus N cycles of array traversal, so the last product is accumulated in PE(N-1,N-1) at edge T+2N-1, where T is the final accept edge.
  - At that edge, state goes to DONE.
- DONE: done=1 and busy=1 for exactly one cycle, then IDLE. out_data is already all-zero.
- Beat counter is K_WIDTH wide. k_len = 2^K_WIDTH-1 must complete without wrap.
- Simultaneous rst and start: rst wins.

Optional Feature:
Macro FEEDER_STALL_CNT_EN.
- Defined: adds output port stall_cnt (K_WIDTH bits). It resets to 0 on rst and on each accepted start, and increments on every FEED cycle with in_valid=0. It saturates at all-ones and holds its value after done until the next start.
- Undefined: no port, no counter; behaviour is otherwise identical.

Test Plan:
- N=4, DATA_WIDTH=32. Reset, then start with k_len=3; beats 1..3 with lane i = 10*beat+i, in_valid held high.
  - Lane i shows 10*b+i exactly i cycles after beat b's accept edge, and 0 otherwise.
  - in_ready drops after 3 accepts.
  - done pulses exactly 2N-1=7 cycles after the last accept edge, then busy=0.
- Same pass with in_valid low for 2 cycles between beats 1 and 2: zero vectors appear skewed in the gap, and done is delayed by 2 cycles. With FEEDER_STALL_CNT_EN, stall_cnt=2.
- start with k_len=0: no in_ready; done pulses on the second cycle after start; out_data stays 0.
- Assert rst during FLUSH (cycle 3 of 7): next cycle out_data=0, busy=0, no done. A new start then completes a normal pass.
- Pulse start during FEED and during FLUSH: ignored, k_len is unchanged, and there is exactly one done per pass.
- End-to-end: two feeders plus a 4x4 array with 3x3-padded A and B, and a PE reset before the pass. At done, each PE result equals the reference matrix product, including 0xFFFFFFFF*0xFFFFFFFF in the 64-bit result.
